// File: rtl/mult32u_share_sched_pkg.sv
// Shared widths and the S1 stage record for the shared-multiplier scheduler.
package mult_sched_pkg;
  localparam int unsigned MULT_W     = 32;
  localparam int unsigned PROD_W     = 64;
  localparam int unsigned PIPE_DEPTH = 2;
  // Tag field sized for the largest supported requester count (16).
  localparam int unsigned ID_MAX_W   = 4;

  typedef struct packed {
    logic [MULT_W-1:0]   a;
    logic [MULT_W-1:0]   b;
    logic [ID_MAX_W-1:0] id;
    logic                valid;
  } stage_t;
endpackage

// File: rtl/mult32u_normal_brentkung.sv
// Combinational 32x32 unsigned multiplier producing the full 64-bit product.
module mult32u_normal_brentkung
  import mult_sched_pkg::*;
(
  input  logic [MULT_W-1:0] i_a,
  input  logic [MULT_W-1:0] i_b,
  output logic [PROD_W-1:0] o_product
);
  assign o_product = PROD_W'(i_a) * PROD_W'(i_b);
endmodule

// File: rtl/mult32u_share_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, advances past the winner on update.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_update,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_winner
);
  logic [ID_W-1:0]      r_ptr;
  logic [2*NUM_REQ-1:0] w_req2;
  logic [NUM_REQ-1:0]   w_rot;
  logic [ID_W-1:0]      w_off;
  logic [ID_W:0]        w_sum;
  logic                 w_found;

  // Rotate the doubled request vector so the pointer position lands at bit 0.
  always_comb begin
    w_req2  = {i_req, i_req};
    w_rot   = NUM_REQ'(w_req2 >> r_ptr);
    w_found = 1'b0;
    w_off   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = ID_W'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
      w_sum = w_sum - (ID_W+1)'(NUM_REQ);
    end
    o_winner = w_sum[ID_W-1:0];
    o_grant  = w_found ? (NUM_REQ'(1) << o_winner) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_update) begin
      r_ptr <= (o_winner == ID_W'(NUM_REQ-1)) ? '0 : o_winner + 1'b1;
    end
  end
endmodule

// File: rtl/mult32u_share_sched.sv
// Shares one 32x32 multiplier among NUM_REQ requesters via a tagged 2-stage pipeline.
module mult32u_share_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [63:0]           rsp_product,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      done_count
);
  stage_t              r_s1;
  stage_t              w_s1_next;
  logic [PROD_W-1:0]   w_product;
  logic [PROD_W-1:0]   r_s2_product;
  logic [ID_W-1:0]     r_s2_id;
  logic                r_s2_valid;
  logic [CNT_W-1:0]    r_done;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_winner;
  logic                w_stall;
  logic                w_accept;

  assign w_stall   = r_s2_valid & ~rsp_ready;
  assign req_ready = (rst | w_stall) ? '0 : w_grant;
  assign w_accept  = |req_ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req_valid),
    .i_update (w_accept),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  always_comb begin
    w_s1_next = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_s1_next.a = req_a[i*MULT_W +: MULT_W];
        w_s1_next.b = req_b[i*MULT_W +: MULT_W];
      end
    end
    w_s1_next.id    = ID_MAX_W'(w_winner);
    w_s1_next.valid = w_accept;
  end

  mult32u_normal_brentkung u_mult (
    .i_a       (r_s1.a),
    .i_b       (r_s1.b),
    .o_product (w_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1.valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s2_product <= '0;
      r_s2_id      <= '0;
      r_done       <= '0;
    end else begin
      if (!w_stall) begin
        r_s1         <= w_s1_next;
        r_s2_valid   <= r_s1.valid;
        r_s2_product <= w_product;
        r_s2_id      <= ID_W'(r_s1.id);
      end
      if (r_s2_valid && rsp_ready) begin
        r_done <= r_done + 1'b1;
      end
    end
  end

  assign rsp_valid   = r_s2_valid;
  assign rsp_product = r_s2_product;
  assign rsp_id      = r_s2_id;
  assign busy        = r_s1.valid | r_s2_valid;
  assign done_count  = r_done;
endmodule

// File: tb/tb_mult32u_share_sched.sv
// Scoreboard bench for mult32u_share_sched: directed vectors, decoupled issue/response monitors.
module tb_mult32u_share_sched;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*32-1:0]  req_a;
  logic [NR*32-1:0]  req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_product;
  logic [IW-1:0]     rsp_id;
  logic              busy;
  logic [31:0]       done_count;

  always #5 clk = ~clk;

  mult32u_share_sched #(.NUM_REQ(NR), .ID_W(IW), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_id      (rsp_id),
    .busy        (busy),
    .done_count  (done_count)
  );

  typedef struct {
    logic [63:0] prod;
    int unsigned id;
  } exp_t;

  exp_t        q[$];
  int          acc_log[$];
  logic [63:0] exp_prod [NR];
  int          checks = 0;
  int          failures = 0;
  bit          m_v1, m_v2;
  int unsigned m_ptr;
  int unsigned m_done;
  int          ord_all  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int          ord_fair [7] = '{1, 3, 1, 3, 0, 1, 3};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Issue side: expected grant and pipeline occupancy, pushes expected responses.
  always @(negedge clk) begin : issue_mon
    logic [NR-1:0] eg;
    bit            st;
    int unsigned   w, idx;
    if (rst) begin
      chk("ready_in_reset", 64'(req_ready), 64'd0);
      m_v1 = 0; m_v2 = 0; m_ptr = 0;
      q.delete();
      acc_log.delete();
    end else begin
      chk("rsp_valid_timing", 64'(rsp_valid), 64'(m_v2));
      chk("busy", 64'(busy), 64'(m_v1 | m_v2));
      st = m_v2 && !rsp_ready;
      eg = '0;
      w  = 0;
      if (!st) begin
        for (int k = 0; k < NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (eg == '0 && req_valid[idx]) begin
            eg[idx] = 1'b1;
            w = idx;
          end
        end
      end
      chk("req_ready", 64'(req_ready), 64'(eg));
      if (eg != '0) begin
        q.push_back('{exp_prod[w], w});
        acc_log.push_back(int'(w));
        m_ptr = (w + 1) % NR;
      end
      if (!st) begin
        m_v2 = m_v1;
        m_v1 = (eg != '0);
      end
    end
  end

  // Response side: pops on each handshake, checks hold stability under backpressure.
  always @(negedge clk) begin : rsp_mon
    exp_t        e;
    bit          held;
    logic [63:0] h_prod;
    logic [IW-1:0] h_id;
    if (rst) begin
      m_done = 0;
      held   = 0;
    end else begin
      if (held) begin
        chk("stall_valid_stable", 64'(rsp_valid), 64'd1);
        chk("stall_product_stable", rsp_product, h_prod);
        chk("stall_id_stable", 64'(rsp_id), 64'(h_id));
      end
      if (rsp_valid && rsp_ready) begin
        chk("done_count", 64'(done_count), 64'(m_done));
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_spurious actual=id %0d product=0x%0h expected=no response", rsp_id, rsp_product);
        end else begin
          e = q.pop_front();
          chk("rsp_product", rsp_product, e.prod);
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
        end
        m_done++;
      end
      held   = rsp_valid && !rsp_ready;
      h_prod = rsp_product;
      h_id   = rsp_id;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    exp_prod[i] = p;
  endtask

  task automatic wait_accepts(input int n);
    int target;
    bit ok;
    target = acc_log.size() + n;
    ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(posedge clk);
      if (acc_log.size() >= target) ok = 1;
    end
    #1;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout actual=%0d expected=%0d", acc_log.size(), target);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(posedge clk);
      if (q.size() == 0 && !m_v1 && !m_v2) ok = 1;
    end
    #1;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", q.size());
    end
  endtask

  task automatic issue_one(input int i, input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
    set_req(i, a, b, p);
    req_valid[i] = 1'b1;
    wait_accepts(1);
    req_valid[i] = 1'b0;
  endtask

  task automatic set_ramp();
    set_req(0, 32'd1, 32'h10, 64'h10);
    set_req(1, 32'd2, 32'h10, 64'h20);
    set_req(2, 32'd3, 32'h10, 64'h30);
    set_req(3, 32'd4, 32'h10, 64'h40);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n_before;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) exp_prod[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_product", rsp_product, 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done_count", 64'(done_count), 64'd0);
    @(posedge clk); #1;

    // Single request from requester 2.
    issue_one(2, 32'd3, 32'd7, 64'd21);
    drain();
    chk("single_grant", 64'(acc_log[0]), 64'd2);
    chk("single_done_count", 64'(done_count), 64'd1);

    // All requesters valid: strict rotation.
    do_reset();
    set_ramp();
    req_valid = '1;
    wait_accepts(8);
    req_valid = '0;
    drain();
    for (int k = 0; k < 8; k++) chk("rotation_order", 64'(acc_log[k]), 64'(ord_all[k]));
    chk("rotation_done_count", 64'(done_count), 64'd8);

    // Backpressure for 5 cycles with requests pending.
    do_reset();
    set_ramp();
    req_valid = '1;
    wait_accepts(3);
    rsp_ready = 1'b0;
    n_before = acc_log.size();
    repeat (5) @(posedge clk);
    #1;
    chk("bp_no_accept", 64'(acc_log.size()), 64'(n_before));
    rsp_ready = 1'b1;
    wait_accepts(5);
    req_valid = '0;
    drain();
    chk("bp_done_count", 64'(done_count), 64'd8);

    // Corner operands.
    do_reset();
    issue_one(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    issue_one(1, 32'h0, 32'hDEAD_BEEF, 64'h0);
    issue_one(3, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    drain();
    chk("corner_done_count", 64'(done_count), 64'd3);

    // Reset with both stages occupied; requests stay asserted through it.
    do_reset();
    set_ramp();
    req_valid = '1;
    wait_accepts(3);
    chk("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done_count", 64'(done_count), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    chk("midrst_first_grant", 64'(acc_log[0]), 64'd0);
    chk("midrst_accepts", 64'(acc_log.size()), 64'd1);
    chk("midrst_done_after", 64'(done_count), 64'd1);

    // Fairness: 1 and 3 alternate; 0 joins and wins right after the wrap.
    do_reset();
    set_req(0, 32'd9, 32'd9, 64'd81);
    set_req(1, 32'd5, 32'd5, 64'd25);
    set_req(3, 32'd6, 32'd7, 64'd42);
    req_valid = 4'b1010;
    wait_accepts(4);
    req_valid = 4'b1011;
    wait_accepts(3);
    req_valid = '0;
    drain();
    for (int k = 0; k < 7; k++) chk("fair_order", 64'(acc_log[k]), 64'(ord_fair[k]));
    chk("fair_done_count", 64'(done_count), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult32u_share_sched.md
Name: mult32u_share_sched

Overview:
- Shares one 32x32 unsigned multiplier datapath between NUM_REQ independent requesters.
- Arbitration is round-robin.
- Each accepted operand pair is tagged with the requester index. The tag is carried through a 2-stage pipeline (operand register, then product register) around a combinational mult32u_normal_brentkung instance.
- Results come back on one shared response channel with the tag attached and full valid/ready backpressure.
- Sits between the compute clients (e.g. MAC/accumulator units) and the multiplier.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..16.
- ID_W, $clog2(NUM_REQ), width of the requester tag.
- CNT_W, 32, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*32  packed multiplicands; requester i occupies bits [32i+31:32i].
- req_b  in  NUM_REQ*32  packed multipliers, same packing.
- rsp_valid  out  1  product register holds a result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_product  out  64  unsigned product a*b.
- rsp_id  out  ID_W  index of the requester that issued the operation.
- busy  out  1  high when either pipeline stage holds a valid entry.
- done_count  out  CNT_W  number of completed response handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- Reset values:
  - rsp_valid=0, rsp_product=0, rsp_id=0.
  - busy=0, done_count=0, req_ready=0 during the reset cycle.
  - Stage-valid bits cleared; round-robin pointer = 0.
  - Operand registers need not be cleared.
- Reset mid-operation: all in-flight entries are discarded with no response, and the pointer returns to 0.
- Pipeline stages:
  - S1 registers a, b, id and v1.
  - The multiplier is combinational on the S1 operands.
  - S2 registers product, id and v2; S2 drives the rsp_* outputs directly.
- Stall = v2 & ~rsp_ready. When stalled, S1 and S2 hold their contents and all req_ready bits are 0.
- When not stalled, every cycle:
  - S2 <= S1.
  - S1 <= granted request, or v1=0 if there is no request.
  - Full throughput: one accept per cycle.
- Latency: a request handshake in cycle t gives rsp_valid in cycle t+2, absent stall. Each stall cycle adds one.
- Arbitration:
  - grant = first asserted req_valid bit, searching from index ptr upward with wrap-around to 0.
  - req_ready[i] = grant[i] & ~stall & ~rst.
  - Grant is combinational from req_valid and is evaluated every cycle.
  - A requester may drop req_valid before it is accepted.
- Pointer update: only on an accepted handshake, ptr <= winner+1, wrapping NUM_REQ-1 to 0. The pointer is unchanged on idle or stall.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0, each requester served exactly once per NUM_REQ accepts.
- Simultaneous events: a response handshake and a new request accept in the same cycle are both legal. That is the normal steady state.
- Arithmetic: product is the full 64-bit unsigned result, with no truncation or sign extension. 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001.
- Response ordering: responses are returned in acceptance order. No reordering; the tag identifies the owner.
- done_count increments on each rsp_valid & rsp_ready cycle and wraps to 0 after all-ones.
- busy = v1 | v2.

Decomposition:
- Package mult_sched_pkg holds:
  - constants MULT_W=32, PROD_W=64, PIPE_DEPTH=2;
  - the stage-record typedef {a, b, id, valid}.
- Sub-module rr_arbiter (NUM_REQ) contains the request vector, pointer register and update-enable input, and produces a one-hot grant plus the encoded winner.
- The top level holds the pipeline registers, the stall logic, the counter and the multiplier instance.

Test Plan:
- Single request, rsp_ready=1: requester 2 with a=3, b=7 accepted at t → rsp_valid at t+2, rsp_product=21, rsp_id=2, done_count=1.
- All 4 requesters valid for 8 cycles, rsp_ready=1:
  - grant order is 0,1,2,3,0,1,2,3;
  - operands a=i+1, b=0x10 → products 0x10, 0x20, 0x30, 0x40 repeated, with matching ids.
- Backpressure: rsp_ready=0 for 5 cycles while requests are pending:
  - rsp outputs are stable;
  - req_ready is all zeros;
  - no loss or duplication after release;
  - done_count equals the number of accepts.
- Corner operands:
  - 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE00000001;
  - 0*0xDEADBEEF → 0;
  - 0x80000000*2 → 0x0000000100000000.
- Reset mid-operation: assert rst with both stages valid → next cycle rsp_valid=0, busy=0, done_count=0, ptr=0; no stale response appears afterwards.
- Pointer fairness: requesters 1 and 3 continuously valid, starting ptr=0 → grants alternate 1,3,1,3; requester 0 raised later is granted right after the next wrap to index 0.
